multi_pattern_comparator: RTL and testbench
===========================================

MULTI_PATTERN_COMPARATOR -- requirements
Module: multi_pattern_comparator

Interface
REQ-001 Parameter DATA_BYTES, default 4: bytes per stream word; the word width is 8*DATA_BYTES.
REQ-002 Parameter PAT_BYTES, default 4, legal range 1..16: bytes per pattern; the pattern width is 8*PAT_BYTES.
REQ-003 Parameter NUM_PAT, default 4: number of independent pattern channels.
REQ-004 Parameter CNT_W, default 16: hit-counter width.
REQ-005 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port clear, input, 1 bit: synchronous flush of history, match state and counter; patterns are kept.
REQ-008 Port data_valid, input, 1 bit: data_in is accepted on this cycle.
REQ-009 Port data_in, input, 8*DATA_BYTES bits: stream word; bits[7:0] is the earliest byte.
REQ-010 Port cfg_we, input, 1 bit: write strobe for one pattern entry.
REQ-011 Port cfg_idx, input, clog2(NUM_PAT) bits (minimum 1): entry to write.
REQ-012 Port cfg_pattern, input, 8*PAT_BYTES bits: pattern value; bits[7:0] is the first byte.
REQ-013 Port cfg_en, input, 1 bit: enable written alongside the pattern.
REQ-014 Port data_out, output, 8*DATA_BYTES bits: accepted word, registered.
REQ-015 Port data_out_valid, output, 1 bit: data_out qualifier.
REQ-016 Port match_vec, output, NUM_PAT bits: per-channel sticky match flags.
REQ-017 Port match_any, output, 1 bit: OR of match_vec.
REQ-018 Port match_idx, output, clog2(NUM_PAT) bits: lowest set index in match_vec; 0 when none is set.
REQ-019 Port hit_count, output, CNT_W bits: saturating count of accepted words that produced at least one hit.
REQ-020 Port armed, output, 1 bit: high when the FSM is in ARMED or HIT.

Function
REQ-021 The block SHALL compare only on accepted words (data_valid=1); with data_valid=0 all state SHALL hold and data_out_valid SHALL be 0.
REQ-022 Per accepted word, the block SHALL evaluate the DATA_BYTES substrings of PAT_BYTES bytes that end in each byte lane of the new word, spanning previously accepted words as needed.
REQ-023 A substring SHALL be eligible only if all of its bytes were accepted since the last rst or clear, tracked by a byte counter that saturates at PAT_BYTES.
REQ-024 Channel i SHALL hit when enabled and equal to any eligible substring; match_vec[i] SHALL set the cycle after the accepting cycle and remain set until rst, clear, or a cfg write to i.
REQ-025 data_out and data_out_valid SHALL be registered copies of data_in and data_valid, so they are aligned with the match update (latency 1).
REQ-026 hit_count SHALL increment by 1 per accepted word with at least one channel hit, including channels already sticky, and SHALL saturate at all-ones.
REQ-027 The FSM SHALL have three states.
- FILL: byte count is below PAT_BYTES.
- ARMED: window is full, no match yet.
- HIT: match_any=1.
REQ-028 FSM transitions SHALL be: FILL->ARMED when the count reaches PAT_BYTES (entering HIT directly if a hit occurs on that same word); ARMED->HIT on the first hit; HIT->ARMED when a cfg write clears the last set bit; any state->FILL on clear.
REQ-029 A cfg_we write SHALL take effect for words accepted in the following cycle and later, and SHALL clear match_vec[cfg_idx].
REQ-030 If a cfg write and a hit on the same index coincide, the cfg clear SHALL win.
REQ-031 If clear and data_valid coincide, clear SHALL win and the word SHALL be dropped (data_out_valid=0).
REQ-032 If clear and cfg_we coincide, both SHALL apply.
REQ-033 A cfg_idx value of NUM_PAT or above SHALL be ignored.

Reset
REQ-034 On rst=1, the block SHALL zero all outputs, history, byte count, hit_count, all patterns and all enables, and SHALL put the FSM in FILL.
REQ-035 rst SHALL take priority over clear, cfg_we and data_valid.
REQ-036 An rst asserted mid-stream SHALL discard partial-window history, so no hit may span the reset boundary.

Structure
REQ-037 A shared package SHALL hold the FSM state typedef (FILL, ARMED, HIT) and the default parameter constants.
REQ-038 A single sub-module, pattern_window_match, SHALL compare one pattern against all DATA_BYTES offsets with eligibility masking and SHALL be instantiated NUM_PAT times.

Verification (defaults 4/4/4/16)
REQ-039 Aligned hit: write entry 0 = 32'hC0A80001 with en=1, send 32'hC0A80001 -> next cycle match_vec=4'b0001, match_idx=0, hit_count=1, armed=1.
REQ-040 Straddled hit: send 32'h0001BEEF then 32'h1234C0A8 -> match_vec[0] sets the cycle after the second word, not after the first.
REQ-041 Gaps and eligibility: data_valid low between the two words of REQ-040 still hits; clear between them gives no hit and the FSM returns to FILL.
REQ-042 Multi-channel: entries 1 and 3 both match one word -> match_vec=4'b1010, match_idx=1, hit_count +1 (not +2); cfg write to entry 1 in the hit cycle -> match_vec=4'b1000.
REQ-043 Saturation and reset: drive 65540 hitting words -> hit_count holds 16'hFFFF; rst mid-stream -> all outputs 0, and a previously loaded pattern no longer hits.

Source files
------------

// File: rtl/multi_pattern_comparator_pkg.sv
// Shared types and default parameters for the multi-pattern stream comparator.
package multi_pattern_comparator_pkg;

  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_PAT_BYTES  = 4;
  localparam int DEF_NUM_PAT    = 4;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } mpc_state_e;

endpackage

// File: rtl/multi_pattern_comparator_pattern_window_match.sv
// Compares one pattern against every substring ending in a lane of the newest word.
module pattern_window_match
  import multi_pattern_comparator_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int PAT_BYTES  = DEF_PAT_BYTES,
  parameter int CNT_BW     = 3
) (
  input  logic [8*(PAT_BYTES-1+DATA_BYTES)-1:0] window,
  input  logic [8*PAT_BYTES-1:0]                pattern,
  input  logic                                  en,
  input  logic [CNT_BW-1:0]                     byte_cnt,
  output logic                                  hit
);

  // window byte 0 is the oldest retained byte; the substring ending in lane j starts at byte j
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (en && (int'(byte_cnt) + j + 1 >= PAT_BYTES) &&
          (window[8*j +: 8*PAT_BYTES] == pattern)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_pattern_comparator.sv
// Streaming comparator: NUM_PAT programmable byte patterns matched across word
// boundaries, with sticky per-channel flags and a saturating hit counter.
//   state | meaning
//   FILL  | fewer than PAT_BYTES bytes accepted since rst/clear
//   ARMED | window full, no sticky match
//   HIT   | at least one sticky match flag set
module multi_pattern_comparator
  import multi_pattern_comparator_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int PAT_BYTES  = DEF_PAT_BYTES,
  parameter int NUM_PAT    = DEF_NUM_PAT,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int IDX_W     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    data_valid,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [8*PAT_BYTES-1:0]  cfg_pattern,
  input  logic                    cfg_en,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    data_out_valid,
  output logic [NUM_PAT-1:0]      match_vec,
  output logic                    match_any,
  output logic [IDX_W-1:0]        match_idx,
  output logic [CNT_W-1:0]        hit_count,
  output logic                    armed
);

  localparam int HB     = (PAT_BYTES > 1) ? PAT_BYTES - 1 : 1;
  localparam int CNT_BW = $clog2(PAT_BYTES + 1);
  localparam int WIN_W  = 8 * (PAT_BYTES - 1 + DATA_BYTES);

  mpc_state_e state_q, state_next;

  logic [8*PAT_BYTES-1:0] pat_q [NUM_PAT];
  logic [NUM_PAT-1:0]     en_q;
  logic [8*HB-1:0]        hist_q, hist_next;
  logic [CNT_BW-1:0]      byte_cnt_q, byte_cnt_next;
  logic [WIN_W-1:0]       window;
  logic [NUM_PAT-1:0]     hit_vec, mv_next;
  logic                   accept, cfg_ok;
  int                     byte_cnt_sum;

  assign accept = data_valid && !clear;
  assign cfg_ok = cfg_we && (int'(cfg_idx) < NUM_PAT);

  // only the last PAT_BYTES-1 bytes are needed to form substrings that straddle words
  generate
    if (PAT_BYTES > 1) begin : g_hist
      assign window    = {data_in, hist_q};
      assign hist_next = window[8*DATA_BYTES +: 8*HB];
    end else begin : g_nohist
      assign window    = data_in;
      assign hist_next = '0;
    end
  endgenerate

  always_comb begin
    byte_cnt_sum  = int'(byte_cnt_q) + DATA_BYTES;
    byte_cnt_next = (byte_cnt_sum >= PAT_BYTES) ? CNT_BW'(PAT_BYTES) : CNT_BW'(byte_cnt_sum);
  end

  generate
    for (genvar i = 0; i < NUM_PAT; i++) begin : g_ch
      pattern_window_match #(
        .DATA_BYTES(DATA_BYTES),
        .PAT_BYTES (PAT_BYTES),
        .CNT_BW    (CNT_BW)
      ) u_match (
        .window  (window),
        .pattern (pat_q[i]),
        .en      (en_q[i]),
        .byte_cnt(byte_cnt_q),
        .hit     (hit_vec[i])
      );
    end
  endgenerate

  // cfg clear is applied last so it beats a same-cycle hit on that index
  always_comb begin
    mv_next = match_vec;
    if (accept) mv_next = mv_next | hit_vec;
    if (clear) mv_next = '0;
    if (cfg_ok) mv_next[cfg_idx] = 1'b0;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      FILL:    if (accept && (byte_cnt_next == CNT_BW'(PAT_BYTES)))
                 state_next = (|mv_next) ? HIT : ARMED;
      ARMED:   if (|mv_next) state_next = HIT;
      HIT:     if (!(|mv_next)) state_next = ARMED;
      default: state_next = FILL;
    endcase
    if (clear) state_next = FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      hist_q         <= '0;
      byte_cnt_q     <= '0;
      match_vec      <= '0;
      hit_count      <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      en_q           <= '0;
      for (int i = 0; i < NUM_PAT; i++) pat_q[i] <= '0;
    end else begin
      state_q        <= state_next;
      match_vec      <= mv_next;
      data_out_valid <= accept;
      if (accept) data_out <= data_in;
      if (clear) begin
        hist_q     <= '0;
        byte_cnt_q <= '0;
        hit_count  <= '0;
      end else if (accept) begin
        hist_q     <= hist_next;
        byte_cnt_q <= byte_cnt_next;
        if ((|hit_vec) && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      end
      if (cfg_ok) begin
        pat_q[cfg_idx] <= cfg_pattern;
        en_q[cfg_idx]  <= cfg_en;
      end
    end
  end

  assign match_any = |match_vec;
  assign armed     = (state_q != FILL);

  always_comb begin
    match_idx = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_multi_pattern_comparator.sv
// Self-checking bench: byte-queue reference model plus directed and random stimulus.
module tb_multi_pattern_comparator;

  localparam int DB = 4;
  localparam int PB = 4;
  localparam int NP = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, clear, data_valid, cfg_we, cfg_en;
  logic [31:0]   data_in, cfg_pattern;
  logic [1:0]    cfg_idx;
  logic [31:0]   data_out;
  logic          data_out_valid, match_any, armed;
  logic [3:0]    match_vec;
  logic [1:0]    match_idx;
  logic [15:0]   hit_count;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [31:0] m_pat [NP];
  logic        m_en  [NP];
  logic [3:0]  m_mv;
  int          m_hc;
  logic [31:0] m_dout;
  logic        m_dv;

  always #5 clk = ~clk;

  multi_pattern_comparator #(
    .DATA_BYTES(DB), .PAT_BYTES(PB), .NUM_PAT(NP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern), .cfg_en(cfg_en),
    .data_out(data_out), .data_out_valid(data_out_valid), .match_vec(match_vec),
    .match_any(match_any), .match_idx(match_idx), .hit_count(hit_count), .armed(armed)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic r, c, v, input logic [31:0] d,
                              input logic we, input logic [1:0] idx,
                              input logic [31:0] p, input logic e);
    logic [3:0]  hits;
    logic [31:0] sub;
    if (r) begin
      q.delete();
      for (int i = 0; i < NP; i++) begin m_pat[i] = '0; m_en[i] = 1'b0; end
      m_mv = '0; m_hc = 0; m_dout = '0; m_dv = 1'b0;
      return;
    end
    hits = '0;
    if (v && !c) begin
      for (int j = 0; j < DB; j++) begin
        q.push_back(d[8*j +: 8]);
        if (q.size() >= PB) begin
          for (int k = 0; k < PB; k++) sub[8*k +: 8] = q[q.size() - PB + k];
          for (int i = 0; i < NP; i++) if (m_en[i] && m_pat[i] == sub) hits[i] = 1'b1;
        end
        if (q.size() > PB) void'(q.pop_front());
      end
    end
    if (c) begin
      q.delete(); m_mv = '0; m_hc = 0;
    end else begin
      m_mv = m_mv | hits;
      if (hits != 0 && m_hc < 65535) m_hc++;
    end
    if (we && int'(idx) < NP) begin
      m_pat[idx] = p; m_en[idx] = e; m_mv[idx] = 1'b0;
    end
    m_dv = v && !c;
    if (m_dv) m_dout = d;
  endtask

  task automatic check_outputs();
    logic [1:0] e_idx;
    e_idx = '0;
    for (int i = NP - 1; i >= 0; i--) if (m_mv[i]) e_idx = 2'(i);
    chk("dout_valid", data_out_valid, m_dv);
    if (m_dv) chk("dout", data_out, m_dout);
    chk("match_vec", match_vec, m_mv);
    chk("match_any", match_any, m_mv != 0);
    chk("match_idx", match_idx, e_idx);
    chk("hit_count", hit_count, m_hc[15:0]);
    chk("armed", armed, q.size() >= PB);
  endtask

  task automatic step(input logic r, c, v, input logic [31:0] d,
                      input logic we, input logic [1:0] idx,
                      input logic [31:0] p, input logic e);
    rst = r; clear = c; data_valid = v; data_in = d;
    cfg_we = we; cfg_idx = idx; cfg_pattern = p; cfg_en = e;
    @(posedge clk);
    model_update(r, c, v, d, we, idx, p, e);
    #1;
    check_outputs();
  endtask

  task automatic idle();                    step(0, 0, 0, '0, 0, 0, '0, 0); endtask
  task automatic send(input logic [31:0] d); step(0, 0, 1, d, 0, 0, '0, 0); endtask
  task automatic do_clear();                step(0, 1, 0, '0, 0, 0, '0, 0); endtask
  task automatic do_rst();                  step(1, 0, 0, '0, 0, 0, '0, 0); endtask
  task automatic cfg(input logic [1:0] idx, input logic [31:0] p, input logic e);
    step(0, 0, 0, '0, 1, idx, p, e);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A;
    return w;
  endfunction

  initial begin
    logic r, c, v, we;
    rst = 1; clear = 0; data_valid = 0; data_in = '0;
    cfg_we = 0; cfg_idx = '0; cfg_pattern = '0; cfg_en = 0;

    do_rst();
    do_rst();
    chk("rst_mv", match_vec, 4'b0000);
    chk("rst_hc", hit_count, 16'h0000);
    idle();

    // aligned hit
    cfg(0, 32'hC0A80001, 1);
    send(32'hC0A80001);
    chk("aligned_mv", match_vec, 4'b0001);
    chk("aligned_idx", match_idx, 2'd0);
    chk("aligned_hc", hit_count, 16'd1);
    chk("aligned_armed", armed, 1'b1);

    // straddled hit
    do_clear();
    send(32'h0001BEEF);
    chk("straddle_first_mv", match_vec, 4'b0000);
    send(32'h1234C0A8);
    chk("straddle_second_mv", match_vec, 4'b0001);

    // gap between words still hits
    do_clear();
    send(32'h0001BEEF);
    idle(); idle();
    send(32'h1234C0A8);
    chk("gap_mv", match_vec, 4'b0001);

    // clear between words breaks eligibility
    do_clear();
    send(32'h0001BEEF);
    do_clear();
    chk("clear_fill", armed, 1'b0);
    send(32'h1234C0A8);
    chk("clear_mv", match_vec, 4'b0000);

    // clear coinciding with data drops the word
    step(0, 1, 1, 32'hC0A80001, 0, 0, '0, 0);
    chk("clear_drop_dv", data_out_valid, 1'b0);

    // multi-channel
    do_clear();
    cfg(1, 32'h11223344, 1);
    cfg(3, 32'h11223344, 1);
    send(32'h11223344);
    chk("multi_mv", match_vec, 4'b1010);
    chk("multi_idx", match_idx, 2'd1);
    chk("multi_hc", hit_count, 16'd1);
    cfg(1, 32'h11223344, 1);
    chk("multi_cfg_mv", match_vec, 4'b1000);
    chk("multi_cfg_idx", match_idx, 2'd3);
    // cfg write on 3 coinciding with a hit on 3: clear wins
    step(0, 0, 1, 32'h11223344, 1, 3, 32'h11223344, 1);
    chk("coincide_mv", match_vec, 4'b0010);

    // randomized phase over a two-symbol alphabet so hits are frequent
    for (int i = 0; i < NP; i++) cfg(2'(i), rnd_word(), 1);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 9) == 0);
      v  = we ? 1'b0 : ($urandom_range(0, 9) < 7);
      step(r, c, v, rnd_word(), we, 2'($urandom_range(0, 3)), rnd_word(),
           $urandom_range(0, 7) != 0);
    end

    // saturation
    do_rst();
    cfg(0, 32'hC0A80001, 1);
    for (int n = 0; n < 65540; n++) send(32'hC0A80001);
    chk("sat_hc", hit_count, 16'hFFFF);

    // reset mid-stream
    send(32'h0001BEEF);
    do_rst();
    chk("rst_mid_mv", match_vec, 4'b0000);
    chk("rst_mid_hc", hit_count, 16'h0000);
    chk("rst_mid_dv", data_out_valid, 1'b0);
    chk("rst_mid_armed", armed, 1'b0);
    send(32'hC0A80001);
    chk("rst_pat_gone", match_vec, 4'b0000);
    do_rst();
    send(32'h0001BEEF);
    do_rst();
    cfg(0, 32'hC0A80001, 1);
    send(32'h1234C0A8);
    chk("rst_no_span", match_vec, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
